regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the register file's single write port between two writeback requesters: A, the main pipeline writeback, and B, the multi-cycle multiply/divide/load unit. Arbitrates with round-robin or fixed priority and drives a registered write command (`wsign`/`waddr`/`wdata`) into the register file. Keeps a 32-entry pending-write scoreboard so issue logic can stall on registers whose writeback has not landed.

## Interface
Parameters:
- `DATA_W`, 32, write data width.
- `ADDR_W`, 5, register address width (32 registers).
- `RR`, 1, arbitration mode: 1 = round-robin, 0 = fixed priority with A over B.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a_valid`  in  1  requester A has a write.
- `a_ready`  out  1  A's write is accepted this cycle.
- `a_addr`  in  ADDR_W  A destination register.
- `a_data`  in  DATA_W  A write data.
- `b_valid`, `b_ready`, `b_addr`, `b_data`: same as A, for requester B.
- `rsv_valid`  in  1  issue reserves a destination register.
- `rsv_addr`  in  ADDR_W  register to reserve.
- `rf_wsign`  out  1  register-file write enable (registered).
- `rf_waddr`  out  ADDR_W  register-file write address (registered).
- `rf_wdata`  out  DATA_W  register-file write data (registered).
- `busy`  out  32  scoreboard: bit r = write to r still pending.
- `err`  out  1  sticky; a reservation hit an already-busy register.

## Operation
- A handshake on X occurs in a cycle where `x_valid && x_ready`.
- `x_valid` must not depend on `x_ready`.
- Once `x_valid` is high, `x_addr`/`x_data` hold until the handshake.
- `x_ready` is combinational: high only when X is valid and X wins arbitration. At most one handshake occurs per cycle.
- Only one requester valid: it wins.
- Both valid, `RR`=1: the winner is the requester not granted most recently.
- Both valid, `RR`=0: A always wins.
- Last-grant pointer:
  - Updates on every handshake.
  - Resets to B, so A wins the first tie.
- Write command register:
  - On a handshake, loads `rf_waddr`/`rf_wdata` from the winner.
  - Sets `rf_wsign` = (addr != 0).
  - With no handshake, `rf_wsign` goes to 0 and `rf_waddr`/`rf_wdata` hold their values.
- Writes to register 0 complete the handshake but never assert `rf_wsign`.
- Scoreboard rules:
  - `rsv_valid` with `rsv_addr` != 0 sets `busy[rsv_addr]`.
  - A handshake to addr r != 0 clears `busy[r]` at the edge where `rf_wsign` commits it (one edge after the handshake).
  - `busy[0]` is constant 0.
- Simultaneous set and clear of the same bit: the set wins.
- `err` sets when `rsv_valid` targets a register whose bit is already 1 and is not being cleared that edge. It is cleared only by reset.
- Reset values (async on `reset_n` low):
  - `rf_wsign`=0, `rf_waddr`=0, `rf_wdata`=0.
  - `busy`=0, `err`=0, pointer=B.
  - A write in flight is dropped.

## Timing
- Handshake in cycle N → `rf_wsign`/`rf_waddr`/`rf_wdata` valid in cycle N+1.
- The register file captures the write at the end of N+1. `busy[r]` falls at that same edge, so a read in N+2 sees the new value.
- Throughput: one write per cycle.
- A requester held off loses at most one cycle under round-robin. Under fixed priority, B can starve.
- `rsv_valid` in cycle N → `busy` bit high from N+1.
- `a_ready`/`b_ready` have no register stage, and the combinational path is valid → ready only.

## Structure
- Shared package `regfile_pkg`:
  - `DATA_W`, `ADDR_W`, `NUM_REGS`=32.
  - `REG_ZERO`=0.
  - Requester enum {REQ_A, REQ_B}.
- Sub-module `rr_arbiter2`: 2-input arbiter containing the last-grant pointer and the `RR` mode.
- Scoreboard and command register live in the top level.

## Test plan
- Lone writes:
  - A writes r5=0x1234 in cycle 1 → `a_ready`=1 in cycle 1.
  - `rf_wsign`=1, `rf_waddr`=5, `rf_wdata`=0x1234 in cycle 2; `rf_wsign`=0 in cycle 3.
- Contention, `RR`=1:
  - A and B valid continuously from reset → grants A,B,A,B.
  - `RR`=0 under the same stimulus → A every cycle and `b_ready` never high.
- Zero register: B writes r0=0xFFFF_FFFF → `b_ready`=1, `rf_wsign` stays 0, `busy[0]`=0.
- Scoreboard:
  - Reserve r7 in cycle 1 → `busy[7]`=1 from cycle 2.
  - A handshake to r7 in cycle 4 → `busy[7]`=0 from cycle 6, i.e. after the edge ending cycle 5.
  - Reserve r7 again in cycle 5, same edge as the clear → `busy[7]` stays 1 and `err`=0.
- Double reserve: reserve r9 twice with no write between → `err`=1, and it stays 1 until reset.
- Reset mid-operation:
  - Pull `reset_n` low during the cycle after a handshake → `rf_wsign`, `busy` and `err` all go 0 immediately.
  - After release, the first tie goes to A.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path.
// Contents: default data/address widths, register count, the hard-wired zero register index,
// and the requester identifier used by the write arbiter's last-grant pointer.
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input write-port arbiter with a last-grant pointer.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   a_valid_i      requester A has a write
//   b_valid_i      requester B has a write
//   a_grant_o      A wins this cycle (combinational, valid -> grant only)
//   b_grant_o      B wins this cycle (combinational, valid -> grant only)
// RR = 1 alternates on ties; RR = 0 always favours A.
module rr_arbiter2
  import regfile_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic a_valid_i,
  input  logic b_valid_i,
  output logic a_grant_o,
  output logic b_grant_o
);

  req_e last_q, last_d;
  logic prefer_a;

  always_comb begin
    // On a tie A wins unless it was the most recent winner in round-robin mode.
    prefer_a  = !RR || (last_q == REQ_B);
    a_grant_o = a_valid_i && (!b_valid_i || prefer_a);
    b_grant_o = b_valid_i && !a_grant_o;
    last_d    = last_q;
    if (a_grant_o) begin
      last_d = REQ_A;
    end else if (b_grant_o) begin
      last_d = REQ_B;
    end
  end

  // Resetting to B hands the first tie to A.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between the main pipeline writeback (A) and the
// multi-cycle unit (B), registers the winning write command and tracks pending writes.
// Ports:
//   clock, reset_n              clock, asynchronous active-low reset
//   a_valid/a_ready/a_addr/a_data   requester A write channel
//   b_valid/b_ready/b_addr/b_data   requester B write channel
//   rsv_valid, rsv_addr         issue reserves a destination register
//   rf_wsign/rf_waddr/rf_wdata  registered register-file write command
//   busy                        bit r set while a write to r is pending
//   err                         sticky: a reservation hit an already-busy register
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
  parameter bit          RR     = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic                rf_wsign,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [NUM_REGS-1:0] busy,
  output logic                err
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REG_ZERO);

  logic                hs;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic                wsign_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NUM_REGS-1:0] busy_q, busy_d, clr_vec, set_vec;
  logic                err_q, err_d;

  rr_arbiter2 #(
    .RR (RR)
  ) u_arb (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .a_valid_i (a_valid),
    .b_valid_i (b_valid),
    .a_grant_o (a_ready),
    .b_grant_o (b_ready)
  );

  assign hs = a_ready | b_ready;

  always_comb begin
    win_addr = b_ready ? b_addr : a_addr;
    win_data = b_ready ? b_data : a_data;
  end

  // Address/data hold when idle; only the enable drops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wsign_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wsign_q <= hs && (win_addr != ZeroAddr);
      if (hs) begin
        waddr_q <= win_addr;
        wdata_q <= win_data;
      end
    end
  end

  // A pending bit clears on the edge the register file commits the write, i.e. while the
  // registered command is presented. A same-edge reservation re-sets it.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (wsign_q) begin
      clr_vec[waddr_q] = 1'b1;
    end
    if (rsv_valid && (rsv_addr != ZeroAddr)) begin
      set_vec[rsv_addr] = 1'b1;
    end
    busy_d           = (busy_q & ~clr_vec) | set_vec;
    busy_d[REG_ZERO] = 1'b0;
    err_d            = err_q | (|(set_vec & busy_q & ~clr_vec));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign rf_wsign = wsign_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        a_valid, b_valid, rsv_valid;
  logic [4:0]  a_addr, b_addr, rsv_addr;
  logic [31:0] a_data, b_data;

  // Index 0: fixed priority, index 1: round-robin.
  logic [1:0]  a_rdy, b_rdy, wsign, err_w;
  logic [4:0]  waddr [2];
  logic [31:0] wdata [2];
  logic [31:0] busy_w [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .RR(1'b0)) dut_fp (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_rdy[0]), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_rdy[0]), .b_addr(b_addr), .b_data(b_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rf_wsign(wsign[0]), .rf_waddr(waddr[0]), .rf_wdata(wdata[0]),
    .busy(busy_w[0]), .err(err_w[0])
  );

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .RR(1'b1)) dut_rr (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_rdy[1]), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_rdy[1]), .b_addr(b_addr), .b_data(b_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rf_wsign(wsign[1]), .rf_waddr(waddr[1]), .rf_wdata(wdata[1]),
    .busy(busy_w[1]), .err(err_w[1])
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_last_b [2] = '{1'b1, 1'b1};  // 1: B was granted most recently
  bit          m_wsign  [2];
  logic [4:0]  m_waddr  [2] = '{5'd0, 5'd0};
  logic [31:0] m_wdata  [2] = '{32'd0, 32'd0};
  bit   [31:0] m_busy   [2];
  bit          m_err    [2];
  bit          ga, gb;

  function automatic void model_grant(int m, output bit g_a, output bit g_b);
    g_a = 1'b0;
    g_b = 1'b0;
    if (a_valid && b_valid) begin
      if (m == 0 || m_last_b[m]) g_a = 1'b1;
      else g_b = 1'b1;
    end else begin
      g_a = a_valid;
      g_b = b_valid;
    end
  endfunction

  always @(posedge clock or negedge reset_n) begin
    for (int m = 0; m < 2; m++) begin
      if (!reset_n) begin
        m_last_b[m] = 1'b1;
        m_wsign[m]  = 1'b0;
        m_waddr[m]  = '0;
        m_wdata[m]  = '0;
        m_busy[m]   = '0;
        m_err[m]    = 1'b0;
      end else begin
        model_grant(m, ga, gb);
        if (rsv_valid && rsv_addr != 0 && m_busy[m][rsv_addr] &&
            !(m_wsign[m] && m_waddr[m] == rsv_addr)) begin
          m_err[m] = 1'b1;
        end
        if (m_wsign[m]) m_busy[m][m_waddr[m]] = 1'b0;
        if (rsv_valid && rsv_addr != 0) m_busy[m][rsv_addr] = 1'b1;
        if (ga || gb) begin
          m_waddr[m]  = gb ? b_addr : a_addr;
          m_wdata[m]  = gb ? b_data : a_data;
          m_wsign[m]  = (m_waddr[m] != 0);
          m_last_b[m] = gb;
        end else begin
          m_wsign[m] = 1'b0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clock) begin
    if (reset_n) begin
      for (int m = 0; m < 2; m++) begin
        bit ea, eb;
        model_grant(m, ea, eb);
        chk($sformatf("model a_ready[m%0d]", m), 32'(a_rdy[m]), 32'(ea));
        chk($sformatf("model b_ready[m%0d]", m), 32'(b_rdy[m]), 32'(eb));
        chk($sformatf("model rf_wsign[m%0d]", m), 32'(wsign[m]), 32'(m_wsign[m]));
        chk($sformatf("model rf_waddr[m%0d]", m), 32'(waddr[m]), 32'(m_waddr[m]));
        chk($sformatf("model rf_wdata[m%0d]", m), wdata[m], m_wdata[m]);
        chk($sformatf("model busy[m%0d]", m), busy_w[m], m_busy[m]);
        chk($sformatf("model err[m%0d]", m), 32'(err_w[m]), 32'(m_err[m]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  logic [3:0] rr_pat;

  initial begin
    reset_n   = 1'b0;
    a_valid   = 1'b0; a_addr = '0; a_data = '0;
    b_valid   = 1'b0; b_addr = '0; b_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0;

    #12;
    chk("reset rf_wsign", 32'(wsign[1]), 32'd0);
    chk("reset busy", busy_w[1], 32'd0);
    chk("reset err", 32'(err_w[1]), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Lone write from A.
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234;
    @(negedge clock);
    chk("lone a_ready", 32'(a_rdy[1]), 32'd1);
    tick();
    a_valid = 1'b0;
    @(negedge clock);
    chk("lone rf_wsign", 32'(wsign[1]), 32'd1);
    chk("lone rf_waddr", 32'(waddr[1]), 32'd5);
    chk("lone rf_wdata", wdata[1], 32'h1234);
    tick();
    @(negedge clock);
    chk("lone rf_wsign drop", 32'(wsign[1]), 32'd0);
    chk("lone rf_waddr hold", 32'(waddr[1]), 32'd5);

    // Contention from reset.
    pulse_reset();
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hAAAA_0001;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'hBBBB_0002;
    rr_pat = 4'b1010;  // bit i set: B wins in contention cycle i
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk($sformatf("rr a_ready c%0d", i), 32'(a_rdy[1]), 32'(!rr_pat[i]));
      chk($sformatf("rr b_ready c%0d", i), 32'(b_rdy[1]), 32'(rr_pat[i]));
      chk($sformatf("fp a_ready c%0d", i), 32'(a_rdy[0]), 32'd1);
      chk($sformatf("fp b_ready c%0d", i), 32'(b_rdy[0]), 32'd0);
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // Zero-register write from B.
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFF_FFFF;
    @(negedge clock);
    chk("r0 b_ready", 32'(b_rdy[1]), 32'd1);
    tick();
    b_valid = 1'b0;
    @(negedge clock);
    chk("r0 rf_wsign", 32'(wsign[1]), 32'd0);
    chk("r0 busy0", 32'(busy_w[1][0]), 32'd0);

    // Scoreboard: reserve r7 (c1), write r7 (c4), re-reserve on the clearing edge (c5).
    pulse_reset();
    rsv_valid = 1'b1; rsv_addr = 5'd7;          // c1
    tick();
    rsv_valid = 1'b0;                           // c2
    @(negedge clock);
    chk("sb busy7 c2", 32'(busy_w[1][7]), 32'd1);
    tick();                                     // c3
    tick();                                     // c4
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
    @(negedge clock);
    chk("sb a_ready c4", 32'(a_rdy[1]), 32'd1);
    tick();                                     // c5
    a_valid = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    @(negedge clock);
    chk("sb rf_wsign c5", 32'(wsign[1]), 32'd1);
    chk("sb busy7 c5", 32'(busy_w[1][7]), 32'd1);
    tick();                                     // c6
    rsv_valid = 1'b0;
    @(negedge clock);
    chk("sb busy7 set wins", 32'(busy_w[1][7]), 32'd1);
    chk("sb err after same-edge", 32'(err_w[1]), 32'd0);
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h78;
    tick();                                     // c7
    a_valid = 1'b0;
    @(negedge clock);
    chk("sb busy7 c7", 32'(busy_w[1][7]), 32'd1);
    tick();                                     // c8
    @(negedge clock);
    chk("sb busy7 cleared", 32'(busy_w[1][7]), 32'd0);

    // Double reservation of r9.
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    tick();
    tick();
    rsv_valid = 1'b0;
    @(negedge clock);
    chk("dbl err rr", 32'(err_w[1]), 32'd1);
    chk("dbl err fp", 32'(err_w[0]), 32'd1);
    tick(); tick(); tick();
    @(negedge clock);
    chk("dbl err sticky", 32'(err_w[1]), 32'd1);

    // Reset in the cycle after a handshake.
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
    tick();
    a_valid = 1'b0;
    #1;
    chk("pre-reset rf_wsign", 32'(wsign[1]), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async rf_wsign", 32'(wsign[1]), 32'd0);
    chk("async busy", busy_w[1], 32'd0);
    chk("async err", 32'(err_w[1]), 32'd0);
    #1;
    reset_n = 1'b1;
    a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h44;
    b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h66;
    @(negedge clock);
    chk("post-reset tie a_ready", 32'(a_rdy[1]), 32'd1);
    chk("post-reset tie b_ready", 32'(b_rdy[1]), 32'd0);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    tick(); tick();
    @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
